// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the 5-stage pipeline; registered stall/flush FSM on negedge clk.
// Optional performance counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned AW        = 5,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [AW-1:0]    ex_rs,
  input  logic [AW-1:0]    ex_rt,
  input  logic [AW-1:0]    ex_wr_addr,
  input  logic             br_taken,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [AW-1:0]    mem_wr_addr,
  input  logic             wb_valid,
  input  logic             wb_reg_write,
  input  logic [AW-1:0]    wb_wr_addr,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned MAX_CYC = (LOAD_LAT > FLUSH_CYC) ? LOAD_LAT : FLUSH_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] STALL_LOAD = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic mem_wr, wb_wr;
  logic hazard, redirect;

  assign mem_wr = mem_valid & mem_reg_write & (mem_wr_addr != '0);
  assign wb_wr  = wb_valid & wb_reg_write & (wb_wr_addr != '0);

  // MEM result is younger than WB, so it takes precedence
  always_comb begin
    fwd_a = 2'b00;
    if (mem_wr && (mem_wr_addr == ex_rs))     fwd_a = 2'b10;
    else if (wb_wr && (wb_wr_addr == ex_rs))  fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_wr && (mem_wr_addr == ex_rt))     fwd_b = 2'b10;
    else if (wb_wr && (wb_wr_addr == ex_rt))  fwd_b = 2'b01;
  end

  assign hazard = ex_valid & ex_mem_read & (ex_wr_addr != '0) & id_valid &
                  ((id_uses_rs & (id_rs == ex_wr_addr)) |
                   (id_uses_rt & (id_rt == ex_wr_addr)));
  assign redirect = ex_valid & br_taken;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    pc_en        = 1'b1;
    pc_sel       = 1'b0;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;

    if (redirect) begin
      // Redirect wins in every state; in FLUSH this reloads the flush window
      pc_sel       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      if (FLUSH_CYC > 1) begin
        state_nx = FLUSH;
        cnt_nx   = FLUSH_LOAD;
      end else begin
        state_nx = RUN;
        cnt_nx   = '0;
      end
    end else begin
      case (state)
        STALL: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          if (cnt <= CW'(1)) begin
            state_nx = RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
        FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (cnt <= CW'(1)) begin
            state_nx = RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
        default: begin
          if (hazard) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nx = STALL;
              cnt_nx   = STALL_LOAD;
            end
          end
        end
      endcase
    end

    if (rst) begin
      state_nx     = RUN;
      cnt_nx       = '0;
      pc_en        = 1'b0;
      pc_sel       = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  assign state_o = state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and flush controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It replaces the purely combinational forwarding and load-use stall logic with a registered state machine. The state machine supports multi-cycle load-use stalls, multi-cycle branch flushes, EX-stage branch redirect and optional performance counters. Its outputs drive the PC enable, the IF/ID enable and flush, the ID/EX bubble mux and the EX-stage ALU operand muxes.

## Interface
- AW, 5, register-address width
- LOAD_LAT, 1, total stall cycles per load-use hazard (≥1)
- FLUSH_CYC, 1, IF/ID flush cycles per taken branch (≥1)
- CNT_W, 16, performance counter width
- clk  in  1  clock; all state updates on negedge clk, same edge as the pipeline registers
- rst  in  1  reset; asynchronous, active-high
- id_valid, id_uses_rs, id_uses_rt  in  1 each  ID instruction valid / reads rs / reads rt
- id_rs, id_rt  in  AW each  ID source addresses
- ex_valid, ex_mem_read  in  1 each  EX instruction valid / is a load
- ex_rs, ex_rt, ex_wr_addr  in  AW each  EX source and destination addresses
- br_taken  in  1  branch resolved taken in EX; qualified by ex_valid
- mem_valid, mem_reg_write  in  1 each  MEM-stage write qualifier
- mem_wr_addr  in  AW  MEM destination address
- wb_valid, wb_reg_write  in  1 each  WB-stage write qualifier
- wb_wr_addr  in  AW  WB destination address
- pc_en  out  1  PC update enable
- pc_sel  out  1  1 = load branch target this cycle
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  load bubble into IF/ID
- id_ex_bubble  out  1  zero ID control signals into ID/EX
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 register file, 10 MEM alu_out, 01 WB result
- state_o  out  2  RUN=00, STALL=01, FLUSH=10
- stall_cnt, flush_cnt  out  CNT_W each  performance counters (see Configuration)

## Operation
- Forwarding is combinational and state-independent.
  - fwd_a=10 when mem_valid & mem_reg_write & mem_wr_addr≠0 & mem_wr_addr==ex_rs.
  - Otherwise fwd_a=01 when the same condition holds for WB.
  - Otherwise fwd_a=00. fwd_b uses the same rules with ex_rt.
  - MEM wins over WB.
- hazard = ex_valid & ex_mem_read & ex_wr_addr≠0 & id_valid & ((id_uses_rs & id_rs==ex_wr_addr) | (id_uses_rt & id_rt==ex_wr_addr)).
- redirect = ex_valid & br_taken. Redirect has priority over hazard in every state.
- RUN state:
  - On redirect: pc_en=1, pc_sel=1, if_id_flush=1, id_ex_bubble=1. Go to FLUSH with cnt=FLUSH_CYC-1 if FLUSH_CYC>1; otherwise stay in RUN.
  - Else on hazard: pc_en=0, if_id_en=0, id_ex_bubble=1. Go to STALL with cnt=LOAD_LAT-1 if LOAD_LAT>1; otherwise stay in RUN.
  - Else: pc_en=1, if_id_en=1, all other control outputs 0.
- STALL state:
  - Outputs as in the RUN hazard case.
  - cnt decrements each cycle. When cnt==1 is seen at the edge, return to RUN.
  - A redirect aborts STALL and takes the RUN redirect action, including entry into FLUSH.
- FLUSH state:
  - pc_en=1, pc_sel=0, if_id_flush=1, id_ex_bubble=1.
  - hazard is ignored. cnt decrements; return to RUN after it expires.
  - A new redirect reloads cnt=FLUSH_CYC-1 and asserts pc_sel=1.
- Counter cnt is ceil(log2(max(LOAD_LAT,FLUSH_CYC)))+1 bits wide.

## Timing
- Reset (asynchronous, held): state=RUN, cnt=0, pc_en=0, pc_sel=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1, counters=0.
- First negedge after reset release: normal RUN behaviour.
- Reset asserted mid-STALL or mid-FLUSH: the block returns to the reset values immediately, with no partial-count carry-over.
- Zero-cycle latency from inputs to all outputs (Mealy). State changes only on negedge clk.
- Load-use with LOAD_LAT=N: pc_en is low for exactly N consecutive cycles, starting in the detect cycle.
- Taken branch with FLUSH_CYC=M: if_id_flush is high for exactly M cycles; pc_sel is high only in the first.
- Register $0 never forwards and never triggers a stall.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined:
  - stall_cnt increments once per cycle with pc_en=0 while not in reset.
  - flush_cnt increments once per redirect.
  - Both counters saturate at 2^CNT_W-1.
- Not defined: stall_cnt and flush_cnt are tied to 0 and no counter flops exist.

## Test plan
- ex_rs=3, mem_valid=1, mem_reg_write=1, mem_wr_addr=3, with WB also writing 3 -> fwd_a=10. MEM invalid -> fwd_a=01. Both addresses 0 -> fwd_a=00.
- LOAD_LAT=3: load to $5 in EX while ID reads rt=$5 -> pc_en=0 and id_ex_bubble=1 for 3 cycles, state_o sequence 00,01,01,00.
- FLUSH_CYC=2: br_taken with ex_valid=1 -> cycle 1 pc_sel=1, if_id_flush=1; cycle 2 pc_sel=0, if_id_flush=1; cycle 3 back in RUN.
- hazard and redirect in the same cycle -> redirect action taken, no stall. Redirect during STALL -> the stall is aborted and FLUSH is entered.
- Reset pulse mid-STALL -> reset output values appear immediately without waiting for clk. After release, RUN with cnt=0.
- PERF_EN defined, CNT_W=2: 5 stall cycles -> stall_cnt=3 (saturated). Without the macro -> stall_cnt=0.
